// File: rtl/divider_monitor.sv
// ----------------------------------------------------------------------------
// divider_monitor
//   Watches a divided clock (clk_div_in, e.g. clk/3) as a data signal in the
//   clk domain. It measures the rising-edge-to-rising-edge period in clk
//   cycles and declares lock after LOCK_COUNT consecutive periods equal to
//   DIV. Once locked, a wrong period or a stalled divided clock sends the
//   monitor into a sticky FAULT state that only clear or reset leaves.
//
//   Optional build macro: DUTY_CHECK_EN also checks the high time of each
//   divided-clock pulse against floor(DIV/2)..ceil(DIV/2) and adds the
//   high_time output port.
//
// Ports
//   clk         source clock, the same one that feeds the divider
//   nreset      asynchronous active-low reset
//   clk_div_in  divided clock under test, sampled as data
//   clear       synchronous; leave FAULT and restart acquisition
//   rise_stb    one-cycle pulse per detected clk_div_in rising edge
//   period      last measured period in clk cycles
//   locked      high while in LOCKED
//   error       high while in FAULT (sticky until clear)
//   high_time   (DUTY_CHECK_EN only) high time of the last completed pulse
// ----------------------------------------------------------------------------
module divider_monitor #(
  parameter int DIV        = 3,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             clk_div_in,
  input  logic             clear,
  output logic             rise_stb,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             error
`ifdef DUTY_CHECK_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam int                GOOD_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  DIV_C     = CNT_W'(DIV);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(2 * DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, FAULT} state_t;

  state_t            state, state_next;
  logic [1:0]        sync;
  logic              prev;
  logic              rise;
  logic              timeout;
  logic              period_ok;
  logic              duty_bad;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good, good_next, good_inc;

  assign rise      = sync[1] & ~prev;
  assign period_ok = (cnt == DIV_C);
  assign timeout   = ~rise & (cnt >= TIMEOUT_C);
  assign good_inc  = good + GOOD_W'(1);

  // NOTE: clk_div_in is treated as asynchronous data, so it passes through a
  // two-flop synchronizer before any decision is made on it. All state here
  // uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync     <= '0;
      prev     <= 1'b0;
      rise_stb <= 1'b0;
    end else begin
      sync     <= {sync[0], clk_div_in};
      prev     <= sync[1];
      rise_stb <= rise;
    end
  end

  // Period counter: restarts at 1 on each rise so a steady clk/DIV shows
  // cnt == DIV in every rise cycle. The first rise out of IDLE and rises in
  // FAULT do not publish a period.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt    <= '0;
      period <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
      if (state == MEASURE || state == LOCKED) period <= cnt;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] HIGH_MIN = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] HIGH_MAX = CNT_W'((DIV + 1) / 2);

  logic [CNT_W-1:0] hcnt;
  logic             fall;

  assign fall = ~sync[1] & prev;

  // The rise cycle itself has sync[1]=1, so the restart value is 1.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hcnt      <= '0;
      high_time <= '0;
    end else begin
      if (rise)                            hcnt <= CNT_W'(1);
      else if (sync[1] && hcnt != CNT_MAX) hcnt <= hcnt + CNT_W'(1);
      if (fall) high_time <= hcnt;
    end
  end

  assign duty_bad = fall & ((hcnt < HIGH_MIN) | (hcnt > HIGH_MAX));
`else
  assign duty_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      good   <= '0;
      locked <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_next;
      good   <= good_next;
      locked <= (state == LOCKED);
      error  <= (state == FAULT);
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    good_next  = good;
    if (clear) begin
      state_next = IDLE;
      good_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_next = MEASURE;
            good_next  = '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            if (period_ok) begin
              good_next = good_inc;
              if (good_inc == LOCK_C) state_next = LOCKED;
            end else begin
              good_next = '0;
            end
          end else if (timeout) begin
            state_next = IDLE;
            good_next  = '0;
          end else if (duty_bad) begin
            good_next = '0;
          end
        end
        LOCKED: begin
          if ((rise && !period_ok) || timeout || duty_bad) state_next = FAULT;
        end
        FAULT: state_next = FAULT;
        default: begin
          state_next = IDLE;
          good_next  = '0;
        end
      endcase
    end
  end

endmodule
